// File: rtl/vga_timing_pkg.sv
// Shared raster types, default 640x480@60 timing constants and small helpers
// used by vga_raster_gen and vga_axis_counter.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned DEF_CLK_DIV   = 2;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  // Wrap-aware successor of a coordinate on an axis of length total.
  function automatic coord_t coord_succ(input coord_t c, input int unsigned total);
    return (c == coord_t'(total - 1)) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus visible/sync decodes of the
// value the counter holds after the current edge (the _n outputs are next-state).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX        = 800,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned VIS        = 640
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   en,
  output coord_t count,
  output coord_t next_count,
  output logic   wrap,
  output logic   vis_n,
  output logic   sync_n
);

  localparam coord_t      LAST    = coord_t'(MAX - 1);
  localparam logic [10:0] VIS_END = 11'(VIS);
  localparam logic [10:0] SYNC_LO = 11'(SYNC_START);
  localparam logic [10:0] SYNC_HI = 11'(SYNC_START + SYNC_LEN);

  coord_t      count_q;
  coord_t      count_d;
  logic [10:0] count_d_ext;

  assign wrap        = (count_q == LAST);
  assign next_count  = coord_succ(count_q, MAX);
  assign count_d     = en ? next_count : count_q;
  assign count_d_ext = {1'b0, count_d};

  // Decoding the post-edge value lets the parent register sync/visible in step
  // with the counter, with no extra pipeline stage.
  assign vis_n  = (count_d_ext < VIS_END);
  assign sync_n = (count_d_ext >= SYNC_LO) && (count_d_ext < SYNC_HI);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster timing source: pixel-rate divider, X/Y scan, syncs, blank and
// frame_start. Define VGA_PREFETCH_EN to add the registered NextX/NextY outputs.
module vga_raster_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_clk,
  output logic   pixel_en,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_start
`ifdef VGA_PREFETCH_EN
  ,
  output coord_t NextX,
  output coord_t NextY
`endif
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int          DW      = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2) begin : g_bad_params
    $error("vga_raster_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 2");
  end

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          pixel_clk_q;
  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  logic          frame_start_q;

  coord_t h_count, h_next, v_count, v_next;
  logic   h_wrap, h_vis_n, h_sync_n;
  logic   v_wrap, v_vis_n, v_sync_n;
  logic   v_en;

  assign pixel_en = (div_q == DIV_LAST);
  assign div_d    = pixel_en ? '0 : div_q + 1'b1;
  assign v_en     = pixel_en & h_wrap;

  vga_axis_counter #(
    .MAX       (H_TOTAL),
    .SYNC_START(H_VISIBLE + H_FRONT),
    .SYNC_LEN  (H_SYNC),
    .VIS       (H_VISIBLE)
  ) u_h_counter (
    .Clk       (Clk),
    .Reset     (Reset),
    .en        (pixel_en),
    .count     (h_count),
    .next_count(h_next),
    .wrap      (h_wrap),
    .vis_n     (h_vis_n),
    .sync_n    (h_sync_n)
  );

  vga_axis_counter #(
    .MAX       (V_TOTAL),
    .SYNC_START(V_VISIBLE + V_FRONT),
    .SYNC_LEN  (V_SYNC),
    .VIS       (V_VISIBLE)
  ) u_v_counter (
    .Clk       (Clk),
    .Reset     (Reset),
    .en        (v_en),
    .count     (v_count),
    .next_count(v_next),
    .wrap      (v_wrap),
    .vis_n     (v_vis_n),
    .sync_n    (v_sync_n)
  );

  // Reset values describe position (0,0) so outputs stay coherent with DrawX/DrawY.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q         <= '0;
      pixel_clk_q   <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pixel_clk_q   <= (div_d >= DIV_HALF);
      hs_q          <= ~h_sync_n;
      vs_q          <= ~v_sync_n;
      blank_q       <= h_vis_n & v_vis_n;
      frame_start_q <= v_en & v_wrap;
    end
  end

  assign pixel_clk   = pixel_clk_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign DrawX       = h_count;
  assign DrawY       = v_count;
  assign frame_start = frame_start_q;

`ifdef VGA_PREFETCH_EN
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);

  coord_t next_x_q;
  coord_t next_y_q;
  coord_t y_at_en;

  // On a pixel_en edge DrawY moves to y_at_en; prefetch looks one pixel past that.
  assign y_at_en = h_wrap ? v_next : v_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      next_x_q <= coord_t'(1);
      next_y_q <= '0;
    end else if (pixel_en) begin
      next_x_q <= coord_succ(h_next, H_TOTAL);
      next_y_q <= (h_next == H_LAST) ? coord_succ(y_at_en, V_TOTAL) : y_at_en;
    end
  end

  assign NextX = next_x_q;
  assign NextY = next_y_q;
`else
  logic unused_next;
  assign unused_next = ^{h_next, v_next};
`endif

endmodule

// File: tb/tb_vga_raster_gen.sv
// Directed bench for vga_raster_gen: default 640x480 instance plus a tiny
// CLK_DIV=4, 14x7 instance used for whole-frame timing.
module tb_vga_raster_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_m, rst_s;
  logic   m_pclk, m_pen, m_hs, m_vs, m_blank, m_fs;
  logic   s_pclk, s_pen, s_hs, s_vs, s_blank, s_fs;
  coord_t m_x, m_y, s_x, s_y;
`ifdef VGA_PREFETCH_EN
  coord_t m_nx, m_ny, s_nx, s_ny;
`endif

  vga_raster_gen u_main (
    .Clk        (clk),
    .Reset      (rst_m),
    .pixel_clk  (m_pclk),
    .pixel_en   (m_pen),
    .hs         (m_hs),
    .vs         (m_vs),
    .blank      (m_blank),
    .DrawX      (m_x),
    .DrawY      (m_y),
    .frame_start(m_fs)
`ifdef VGA_PREFETCH_EN
    ,
    .NextX      (m_nx),
    .NextY      (m_ny)
`endif
  );

  vga_raster_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .Clk        (clk),
    .Reset      (rst_s),
    .pixel_clk  (s_pclk),
    .pixel_en   (s_pen),
    .hs         (s_hs),
    .vs         (s_vs),
    .blank      (s_blank),
    .DrawX      (s_x),
    .DrawY      (s_y),
    .frame_start(s_fs)
`ifdef VGA_PREFETCH_EN
    ,
    .NextX      (s_nx),
    .NextY      (s_ny)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int ex, ey, idx;
  int pos_bad, pe_bad, pc_bad, hs_bad, vs_bad, bl_bad, fs_bad, nx_bad;
  int pe_cnt, hs_lo, hs_first, hs_last, bl_lo, bl_first;
  int fs_cnt, last_fs, period, pe_acc, pe_between, run, max_run, hs_px, vs_px;

  initial begin
    rst_m = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_x", m_x, 0);
    check("rst_y", m_y, 0);
    check("rst_hs", m_hs, 1);
    check("rst_vs", m_vs, 1);
    check("rst_blank", m_blank, 1);
    check("rst_pclk", m_pclk, 0);
    check("rst_pen", m_pen, 0);
    check("rst_fs", m_fs, 0);
`ifdef VGA_PREFETCH_EN
    check("rst_nx", m_nx, 1);
    check("rst_ny", m_ny, 0);
`endif

    // One full line on the default timing, released on a negedge.
    rst_m = 1'b0;
    pos_bad = 0; pe_bad = 0; pc_bad = 0; hs_bad = 0; bl_bad = 0; vs_bad = 0; nx_bad = 0;
    pe_cnt = 0; hs_lo = 0; hs_first = -1; hs_last = -1; bl_lo = 0; bl_first = -1;
    for (int k = 1; k <= 1600; k++) begin
      @(negedge clk);
      ex = (k / 2) % 800;
      ey = k / 1600;
      if (m_x !== ex[9:0] || m_y !== ey[9:0]) pos_bad++;
      if (m_pen !== (k % 2 == 1)) pe_bad++;
      if (m_pclk !== (k % 2 == 1)) pc_bad++;
      if (m_hs !== !(ex >= 656 && ex < 752)) hs_bad++;
      if (m_blank !== (ex < 640 && ey < 480)) bl_bad++;
      if (m_vs !== 1'b1 || m_fs !== 1'b0) vs_bad++;
`ifdef VGA_PREFETCH_EN
      if (m_nx !== 10'((ex + 1) % 800) || m_ny !== 10'((ex == 799) ? (ey + 1) % 525 : ey)) nx_bad++;
`endif
      if (m_pen === 1'b1) pe_cnt++;
      if (k % 2 == 1) begin
        if (m_hs === 1'b0) begin
          hs_lo++;
          if (hs_first < 0) hs_first = ex;
          hs_last = ex;
        end
        if (m_blank === 1'b0) begin
          bl_lo++;
          if (bl_first < 0) bl_first = ex;
        end
      end
    end
    check("line_pos", pos_bad, 0);
    check("line_pen_cadence", pe_bad, 0);
    check("line_pclk", pc_bad, 0);
    check("line_hs", hs_bad, 0);
    check("line_blank", bl_bad, 0);
    check("line_vs_fs", vs_bad, 0);
    check("line_pen_count", pe_cnt, 800);
    check("line_hs_low_px", hs_lo, 96);
    check("line_hs_first", hs_first, 656);
    check("line_hs_last", hs_last, 751);
    check("line_blank_low_px", bl_lo, 160);
    check("line_blank_first", bl_first, 640);
    check("line_end_x", m_x, 0);
    check("line_end_y", m_y, 1);
`ifdef VGA_PREFETCH_EN
    check("line_prefetch", nx_bad, 0);
`endif

    // Advance to (799,10) with pixel_en high, then across the line wrap.
    for (int k = 1601; k <= 17599; k++) @(negedge clk);
    check("wrap_pre_x", m_x, 799);
    check("wrap_pre_y", m_y, 10);
    check("wrap_pre_pen", m_pen, 1);
    check("wrap_pre_blank", m_blank, 0);
    check("wrap_pre_vs", m_vs, 1);
`ifdef VGA_PREFETCH_EN
    check("wrap_pre_nx", m_nx, 0);
    check("wrap_pre_ny", m_ny, 11);
`endif
    @(negedge clk);
    check("wrap_x", m_x, 0);
    check("wrap_y", m_y, 11);
    check("wrap_blank", m_blank, 1);

    // Asynchronous reset between edges at (300,11) while pixel_clk is high.
    for (int k = 17601; k <= 18201; k++) @(negedge clk);
    check("mid_pre_x", m_x, 300);
    check("mid_pre_pclk", m_pclk, 1);
    #1 rst_m = 1'b1;
    #1;
    check("mid_rst_x", m_x, 0);
    check("mid_rst_y", m_y, 0);
    check("mid_rst_hs", m_hs, 1);
    check("mid_rst_vs", m_vs, 1);
    check("mid_rst_blank", m_blank, 1);
    check("mid_rst_pclk", m_pclk, 0);
    check("mid_rst_pen", m_pen, 0);
`ifdef VGA_PREFETCH_EN
    check("mid_rst_nx", m_nx, 1);
`endif

    // Small timing: three whole frames of 98 pixels x 4 clocks.
    @(negedge clk);
    check("s_rst_x", s_x, 0);
    check("s_rst_fs", s_fs, 0);
    rst_s = 1'b0;
    pos_bad = 0; pe_bad = 0; pc_bad = 0; hs_bad = 0; vs_bad = 0; bl_bad = 0; fs_bad = 0;
    nx_bad = 0; fs_cnt = 0; last_fs = 0; period = 0; pe_acc = 0; pe_between = 0;
    run = 0; max_run = 0; hs_px = 0; vs_px = 0;
    for (int k = 1; k <= 1186; k++) begin
      @(negedge clk);
      idx = (k / 4) % 98;
      ex  = idx % 14;
      ey  = idx / 14;
      if (s_x !== ex[9:0] || s_y !== ey[9:0]) pos_bad++;
      if (s_pen !== (k % 4 == 3)) pe_bad++;
      if (s_pclk !== (k % 4 >= 2)) pc_bad++;
      if (s_hs !== !(ex >= 10 && ex < 12)) hs_bad++;
      if (s_vs !== !(ey == 5)) vs_bad++;
      if (s_blank !== (ex < 8 && ey < 4)) bl_bad++;
      if (s_fs !== (k % 392 == 0)) fs_bad++;
`ifdef VGA_PREFETCH_EN
      if (s_nx !== 10'((ex + 1) % 14) || s_ny !== 10'((ex == 13) ? (ey + 1) % 7 : ey)) nx_bad++;
`endif
      if (s_pen === 1'b1) begin
        pe_acc++;
        if (k <= 392 && s_hs === 1'b0) hs_px++;
        if (k <= 392 && s_vs === 1'b0) vs_px++;
      end
      if (s_fs === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
        fs_cnt++;
        if (last_fs > 0) begin
          period     = k - last_fs;
          pe_between = pe_acc;
        end
        pe_acc  = 0;
        last_fs = k;
      end else begin
        run = 0;
      end
    end
    check("s_pos", pos_bad, 0);
    check("s_pen_cadence", pe_bad, 0);
    check("s_pclk", pc_bad, 0);
    check("s_hs", hs_bad, 0);
    check("s_vs", vs_bad, 0);
    check("s_blank", bl_bad, 0);
    check("s_fs_timing", fs_bad, 0);
    check("s_fs_count", fs_cnt, 3);
    check("s_frame_clk", period, 392);
    check("s_frame_pen", pe_between, 98);
    check("s_fs_width", max_run, 1);
    check("s_hs_low_px", hs_px, 14);
    check("s_vs_low_px", vs_px, 14);
`ifdef VGA_PREFETCH_EN
    check("s_prefetch", nx_bad, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
